rom_t_reader: RTL and testbench

- Sequencer on the reader side of the coefficient ROM interface (address / chip-enable / read-enable / tristate-control out, data in).
- On a start pulse it walks ROM addresses 0..NUM_COEF-1 and waits the ROM access time for each address.
- It captures each word and streams it to the downstream Chebyshev filter MAC over a valid/ready handshake, one coefficient at a time, tagged with its index.

---
 rtl/rom_t_reader_pkg.sv | 21 ++
 rtl/rom_t_reader_out_stage.sv | 59 +++++
 rtl/rom_t_reader.sv | 153 +++++++++++++++
 tb/tb_rom_t_reader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_t_reader_pkg.sv
// Shared types and constants for the coefficient ROM reader.
package rom_t_reader_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // The reader drives the ROM bus only while an access is in flight.
  function automatic logic rom_bus_owned(input state_e st);
    return (st == ST_SETUP) || (st == ST_WAIT);
  endfunction

endpackage

// File: rtl/rom_t_reader_out_stage.sv
// Valid/ready holding register for one captured coefficient and its index.
module rom_t_reader_out_stage
  import rom_t_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              c_clk,
  input  logic              c_rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] index_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] index_out,
  output logic              valid_out
);

  logic [DATA_W-1:0] data_d,  data_q;
  logic [ADDR_W-1:0] index_d, index_q;
  logic              valid_d, valid_q;

  // Next-state: abort beats load, load beats clear; payload only changes on load.
  always_comb begin
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    if (abort) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
      index_d = index_in;
    end else if (clear) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register with asynchronous reset.
  always_ff @(posedge c_clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      data_q  <= {DATA_W{1'b0}};
      index_q <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign index_out = index_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/rom_t_reader.sv
// Coefficient ROM reader: sweeps addresses 0..NUM_COEF-1, waits the ROM access
// time, and streams each word downstream over valid/ready.
module rom_t_reader
  import rom_t_reader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_COEF = 8,
  parameter int ROM_WAIT = 1
) (
  input  logic              c_clk,
  input  logic              c_rst_n,
  input  logic              c_start,
  input  logic              c_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rom_address,
  output logic              o_rom_read_en,
  output logic              o_rom_ce,
  output logic              o_rom_tri_output,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_coef_data,
  output logic [ADDR_W-1:0] o_coef_index,
  output logic              o_coef_valid,
  input  logic              i_coef_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COEF - 1);
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(ROM_WAIT);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] addr_d,  addr_q;
  logic [CNT_W-1:0]  cnt_d,   cnt_q;
  logic              busy_d,  busy_q;
  logic              done_d,  done_q;
  logic              ce_d,    ce_q;
  logic              tri_d,   tri_q;
  logic              load_s, clear_s, abort_s, valid_s, own_s;

  // Sequencer next state; abort in any active state returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    clear_s = 1'b0;
    abort_s = 1'b0;
    if (c_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      abort_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (c_start && !c_abort) begin
            addr_d  = {ADDR_W{1'b0}};
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETUP: begin
          cnt_d   = WAIT_LOAD;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            load_s  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (valid_s && i_coef_ready) begin
            clear_s = 1'b1;
            if (addr_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_SETUP;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Status and ROM controls are derived from the next state so they land registered.
  always_comb begin
    own_s  = rom_bus_owned(state_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    ce_d   = own_s;
    tri_d  = !own_s;
  end

  // State, address, wait counter and registered outputs.
  always_ff @(posedge c_clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_q    <= 1'b0;
      tri_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ce_q    <= ce_d;
      tri_q   <= tri_d;
    end
  end

  rom_t_reader_out_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_stage (
    .c_clk     (c_clk),
    .c_rst_n   (c_rst_n),
    .load      (load_s),
    .clear     (clear_s),
    .abort     (abort_s),
    .data_in   (i_rom_data),
    .index_in  (addr_q),
    .data_out  (o_coef_data),
    .index_out (o_coef_index),
    .valid_out (valid_s)
  );

  assign o_coef_valid     = valid_s;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_rom_address    = addr_q;
  assign o_rom_ce         = ce_q;
  assign o_rom_read_en    = ce_q;
  assign o_rom_tri_output = tri_q;

endmodule

// File: tb/tb_rom_t_reader.sv
// Bench for rom_t_reader: three configurations (8 words/wait 1, 8 words/wait 4,
// 1 word/wait 1), each with its own timed ROM model, checked against a
// cycle-count model of the handshake stream.
module tb_rom_t_reader;

  localparam int N_INST = 3;
  localparam int AW = 3;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  logic [N_INST-1:0] start, abort, ready, busy, done, rom_re, rom_ce, rom_tri, coef_valid;
  logic [N_INST-1:0][AW-1:0] rom_addr, coef_index;
  logic [N_INST-1:0][DW-1:0] coef_data;
  logic [DW-1:0] rom_img [N_INST][8];
  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rw_of(input int g);
    return (g == 1) ? 4 : 1;
  endfunction

  function automatic int nc_of(input int g);
    return (g == 2) ? 1 : 8;
  endfunction

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int RW = (g == 1) ? 4 : 1;
    localparam int NC = (g == 2) ? 1 : 8;
    int stable_cnt;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] rom_bus;

    // ROM model: counts cycles the address has been presented with the ROM enabled.
    always @(posedge clk) begin
      if (!rst_n) begin
        stable_cnt <= 0;
      end else if (rom_ce[g] && rom_re[g] && !rom_tri[g]) begin
        stable_cnt <= (rom_addr[g] == last_addr) ? stable_cnt + 1 : 1;
      end else begin
        stable_cnt <= 0;
      end
      last_addr <= rom_addr[g];
    end

    // Bus shows the word only after the access time, garbage otherwise.
    always_comb begin
      if (rom_ce[g] && rom_re[g] && !rom_tri[g] && stable_cnt >= RW)
        rom_bus = rom_img[g][rom_addr[g]];
      else
        rom_bus = 16'hDEAD ^ {13'd0, rom_addr[g]};
    end

    rom_t_reader #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_COEF(NC), .ROM_WAIT(RW)
    ) u_dut (
      .c_clk(clk), .c_rst_n(rst_n), .c_start(start[g]), .c_abort(abort[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_rom_address(rom_addr[g]),
      .o_rom_read_en(rom_re[g]), .o_rom_ce(rom_ce[g]), .o_rom_tri_output(rom_tri[g]),
      .i_rom_data(rom_bus), .o_coef_data(coef_data[g]), .o_coef_index(coef_index[g]),
      .o_coef_valid(coef_valid[g]), .i_coef_ready(ready[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_all(input string name);
    for (int g = 0; g < N_INST; g++) begin
      vectors++;
      if (busy[g] !== 1'b0 || done[g] !== 1'b0 || rom_addr[g] !== 3'd0 || rom_re[g] !== 1'b0 ||
          rom_ce[g] !== 1'b0 || rom_tri[g] !== 1'b1 || coef_data[g] !== 16'd0 ||
          coef_index[g] !== 3'd0 || coef_valid[g] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s inst=%0d: busy=%b done=%b addr=%0d re=%b ce=%b tri=%b data=%h idx=%0d valid=%b, required 0 0 0 0 0 1 0000 0 0",
                 name, g, busy[g], done[g], rom_addr[g], rom_re[g], rom_ce[g], rom_tri[g],
                 coef_data[g], coef_index[g], coef_valid[g]);
      end
    end
  endtask

  // One sweep against the timing model: each word valid exactly 1+ROM_WAIT
  // cycles after its trigger edge (start or previous handshake).
  task automatic run_sweep(input int g, input int ready_pct, input bit noisy,
                           input int stall_idx, input int abort_idx);
    int rw, nc, exp_idx, cyc, budget, stall_cnt;
    bit fin, exp_v;
    rw = rw_of(g);
    nc = nc_of(g);
    exp_idx = 0; cyc = 0; stall_cnt = 0; fin = 1'b0; budget = 2000;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    while (!fin && budget > 0) begin
      budget--;
      if (exp_idx == nc) begin
        vectors++;
        if (done[g] !== 1'b1 || busy[g] !== 1'b1 || coef_valid[g] !== 1'b0 ||
            rom_ce[g] !== 1'b0 || rom_tri[g] !== 1'b1) begin
          miscompares++;
          $display("FAIL done_cycle inst=%0d: done=%b busy=%b valid=%b ce=%b tri=%b, required 1 1 0 0 1",
                   g, done[g], busy[g], coef_valid[g], rom_ce[g], rom_tri[g]);
        end
        tick();
        vectors++;
        if (done[g] !== 1'b0 || busy[g] !== 1'b0) begin
          miscompares++;
          $display("FAIL after_done inst=%0d: done=%b busy=%b, required 0 0", g, done[g], busy[g]);
        end
        fin = 1'b1;
      end else begin
        exp_v = (cyc >= 1 + rw);
        vectors++;
        if (coef_valid[g] !== exp_v || done[g] !== 1'b0 || busy[g] !== 1'b1) begin
          miscompares++;
          $display("FAIL valid_timing inst=%0d idx=%0d cyc=%0d: valid=%b done=%b busy=%b, required %b 0 1",
                   g, exp_idx, cyc, coef_valid[g], done[g], busy[g], exp_v);
        end
        vectors++;
        if (exp_v) begin
          if (coef_data[g] !== rom_img[g][exp_idx] || coef_index[g] !== exp_idx[AW-1:0] ||
              rom_ce[g] !== 1'b0 || rom_re[g] !== 1'b0 || rom_tri[g] !== 1'b1) begin
            miscompares++;
            $display("FAIL word inst=%0d: data=%h idx=%0d ce=%b re=%b tri=%b, required %h %0d 0 0 1",
                     g, coef_data[g], coef_index[g], rom_ce[g], rom_re[g], rom_tri[g],
                     rom_img[g][exp_idx], exp_idx);
          end
        end else begin
          if (rom_ce[g] !== 1'b1 || rom_re[g] !== 1'b1 || rom_tri[g] !== 1'b0 ||
              rom_addr[g] !== exp_idx[AW-1:0]) begin
            miscompares++;
            $display("FAIL rom_access inst=%0d cyc=%0d: ce=%b re=%b tri=%b addr=%0d, required 1 1 0 %0d",
                     g, cyc, rom_ce[g], rom_re[g], rom_tri[g], rom_addr[g], exp_idx);
          end
        end
        if (exp_idx == abort_idx && cyc == 1) begin
          abort[g] = 1'b1;
          ready[g] = 1'b1;
          tick();
          abort[g] = 1'b0;
          vectors++;
          if (busy[g] !== 1'b0 || coef_valid[g] !== 1'b0 || rom_ce[g] !== 1'b0 ||
              rom_re[g] !== 1'b0 || rom_tri[g] !== 1'b1 || done[g] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state inst=%0d: busy=%b valid=%b ce=%b re=%b tri=%b done=%b, required 0 0 0 0 1 0",
                     g, busy[g], coef_valid[g], rom_ce[g], rom_re[g], rom_tri[g], done[g]);
          end
          for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (coef_valid[g] !== 1'b0 || done[g] !== 1'b0 || busy[g] !== 1'b0) begin
              miscompares++;
              $display("FAIL after_abort inst=%0d: valid=%b done=%b busy=%b, required 0 0 0",
                       g, coef_valid[g], done[g], busy[g]);
            end
          end
          fin = 1'b1;
        end else begin
          ready[g] = ($urandom_range(0, 99) < ready_pct);
          if (exp_v && exp_idx == stall_idx && stall_cnt < 5) begin
            ready[g] = 1'b0;
            stall_cnt++;
          end
          if (noisy) start[g] = 1'($urandom_range(0, 1));
          if (exp_v && ready[g]) begin
            exp_idx++;
            cyc = 0;
            if (exp_idx == nc) start[g] = 1'b0;
          end else begin
            cyc++;
          end
          tick();
        end
      end
    end
    start[g] = 1'b0;
    ready[g] = 1'b0;
    if (!fin) begin
      miscompares++;
      $display("FAIL sweep_timeout inst=%0d: words=%0d, required %0d", g, exp_idx, nc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_all("reset_state");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_plain_sweep();
    run_sweep(0, 100, 1'b0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_sweep(0, 100, 1'b0, 3, -1);
  endtask

  task automatic test_rom_wait4();
    run_sweep(1, 100, 1'b0, -1, -1);
    run_sweep(1, 60, 1'b1, 2, -1);
  endtask

  task automatic test_abort();
    run_sweep(0, 100, 1'b0, -1, 5);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b0 || rom_ce[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL start_abort_idle: busy=%b ce=%b, required 0 0", busy[0], rom_ce[0]);
    end
    run_sweep(0, 100, 1'b0, -1, -1);
  endtask

  task automatic test_async_reset();
    int n;
    ready[0] = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (coef_valid[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (coef_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reach_hold: valid=%b, required 1", coef_valid[0]);
    end
    #2;
    rst_n = 1'b0;
    start[0] = 1'b1;
    #1;
    check_idle_all("async_reset");
    tick();
    tick();
    check_idle_all("start_in_reset");
    start[0] = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check_idle_all("after_reset_release");
  endtask

  task automatic test_num_coef_one();
    run_sweep(2, 100, 1'b1, -1, -1);
    run_sweep(2, 40, 1'b1, 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int g = 0; g < N_INST; g++)
        for (int a = 0; a < 8; a++) rom_img[g][a] = 16'($urandom);
      run_sweep(0, $urandom_range(30, 100), 1'b1, $urandom_range(0, 7), -1);
      run_sweep(1, $urandom_range(30, 100), 1'b1, $urandom_range(0, 7), -1);
      run_sweep(2, $urandom_range(30, 100), 1'b1, 0, -1);
    end
  endtask

  initial begin
    logic [DW-1:0] base [8];
    vectors = 0;
    miscompares = 0;
    start = '0;
    abort = '0;
    ready = '0;
    base = '{16'h7FFF, 16'h0FFF, 16'h8400, 16'hD100, 16'h703F, 16'h4B0F, 16'hA284, 16'h9D91};
    for (int g = 0; g < N_INST; g++)
      for (int a = 0; a < 8; a++) rom_img[g][a] = base[a];
    test_reset();
    test_plain_sweep();
    test_backpressure();
    test_rom_wait4();
    test_abort();
    test_async_reset();
    test_num_coef_one();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
